// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter: turns the async FIFO's rd_en/rempty/dout port into a valid/ready stream
// with a small prefetch buffer. Optional stall counter enabled by FIFO_RD_STALL_CNT_EN.
module fifo_rd_stream_adapter #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 3
) (
    input  logic             rclk,
    input  logic             rst_n,
    input  logic             fifo_rempty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
`ifdef FIFO_RD_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [OCC_W:0]   DEPTH_L = (OCC_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(BUF_DEPTH - 1);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [WIDTH-1:0] buf_d [BUF_DEPTH];
    // Holds reads off while rst_n is low, even if the FIFO side still reports data.
    logic             run_q;
    logic [OCC_W:0]   level;
    logic             push;
    logic             pop;

    always_comb begin
        level      = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};
        fifo_rd_en = run_q && !fifo_rempty && (level < DEPTH_L);
        m_valid    = (occ_q != '0);
        m_data     = buf_q[head_q];
        push       = inflight_q;
        pop        = m_valid && m_ready;

        inflight_d = fifo_rd_en;
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        buf_d      = buf_q;

        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - OCC_W'(1);
        end

        if (push) begin
            buf_d[tail_q] = fifo_dout;
            tail_d        = (tail_q == PTR_MAX) ? '0 : tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = (head_q == PTR_MAX) ? '0 : head_q + PTR_W'(1);
        end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            run_q      <= 1'b1;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            buf_q      <= buf_d;
        end
    end

`ifdef FIFO_RD_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid && !m_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
